// File: rtl/codeword_deserializer.sv
// codeword_deserializer: oversampled UART-style receiver for 11-bit
// Hamming codewords, framed start(0) / 11 bits LSB first / stop(1).
// Ports:
//   clk, rst_n     clock and async active-low reset
//   rx_line        asynchronous idle-high serial input
//   code_word      recovered {p3,p2,p1,data[7:0]}, bit 0 received first
//   code_valid     code_word holds an undelivered codeword
//   code_ready     consumer accepts when code_valid && code_ready
//   framing_error  one-cycle pulse, stop bit sampled low
//   overrun        one-cycle pulse, word completed while holding reg full
//   busy           receiver is inside a frame
module codeword_deserializer #(
    parameter int CLKS_PER_BIT = 4,
    parameter int SYNC_STAGES  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_line,
    output logic [10:0] code_word,
    output logic        code_valid,
    input  logic        code_ready,
    output logic        framing_error,
    output logic        overrun,
    output logic        busy
);

    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] BAUD_MID  = CW'(HALF - 1);
    localparam logic [3:0]    LAST_BIT  = 4'd10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [SYNC_STAGES-1:0] r_sync;
    logic [CW-1:0]       r_baud;
    logic [3:0]          r_bit_idx;
    logic [10:0]         r_shift;
    logic [10:0]         r_code_word;
    logic                r_code_valid;
    logic                r_framing_error;
    logic                r_overrun;

    logic                w_rx_s;
    logic                w_busy;
    logic                w_start_samp;
    logic                w_bit_samp;
    logic                w_stop_samp;
    logic                w_good;
    logic                w_load;

    // Synchronizer flops idle high so reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], rx_line};
        end
    end

    assign w_rx_s = r_sync[SYNC_STAGES-1];

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM: next state
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (!w_rx_s) w_next = S_START;
            S_START: if (w_start_samp) w_next = w_rx_s ? S_IDLE : S_DATA;
            S_DATA:  if (w_bit_samp && r_bit_idx == LAST_BIT) w_next = S_STOP;
            S_STOP:  if (w_stop_samp) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // FSM: outputs and sample strobes
    always_comb begin
        w_busy       = (r_state != S_IDLE);
        w_start_samp = (r_state == S_START) && (r_baud == BAUD_MID);
        w_bit_samp   = (r_state == S_DATA)  && (r_baud == BAUD_LAST);
        w_stop_samp  = (r_state == S_STOP)  && (r_baud == BAUD_LAST);
    end

    // Baud/bit counters and shift register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    r_baud <= '0;
                end
                S_START: begin
                    r_baud    <= w_start_samp ? '0 : r_baud + 1'b1;
                    r_bit_idx <= '0;
                end
                S_DATA: begin
                    if (w_bit_samp) begin
                        r_baud             <= '0;
                        r_shift[r_bit_idx] <= w_rx_s;
                        if (r_bit_idx != LAST_BIT) begin
                            r_bit_idx <= r_bit_idx + 4'd1;
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                S_STOP: begin
                    r_baud <= w_stop_samp ? '0 : r_baud + 1'b1;
                end
                default: r_baud <= '0;
            endcase
        end
    end

    // A good stop loads the holding register if it is empty or being
    // drained in this same cycle; otherwise the new word is dropped.
    assign w_good = w_stop_samp && w_rx_s;
    assign w_load = w_good && (!r_code_valid || code_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_code_word     <= '0;
            r_code_valid    <= 1'b0;
            r_framing_error <= 1'b0;
            r_overrun       <= 1'b0;
        end else begin
            r_framing_error <= w_stop_samp && !w_rx_s;
            r_overrun       <= w_good && !w_load;
            if (w_load) begin
                r_code_word  <= r_shift;
                r_code_valid <= 1'b1;
            end else if (r_code_valid && code_ready) begin
                r_code_valid <= 1'b0;
            end
        end
    end

    assign code_word     = r_code_word;
    assign code_valid    = r_code_valid;
    assign framing_error = r_framing_error;
    assign overrun       = r_overrun;
    assign busy          = w_busy;

endmodule

// File: doc/codeword_deserializer.md
Name: codeword_deserializer

Overview:
- Receive side of the protected data link, directly upstream of the Hamming-style decoder.
- Recovers 11-bit codewords ({p3,p2,p1,data[7:0]}) from an asynchronous, oversampled, idle-high serial line.
- Validates start and stop framing, then presents each codeword on a valid/ready interface; the decoder consumes it there for syndrome check and correction.
- Flags framing errors and overruns as single-cycle pulses.

Parameters:
- CLKS_PER_BIT, 4: clk cycles per serial bit. Must be >= 2. HALF = CLKS_PER_BIT/2 (integer division).
- SYNC_STAGES, 2: flops in the rx_line synchronizer. Must be >= 2.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rx_line  in  1  serial input, idle high, asynchronous to clk.
- code_word  out  11  recovered codeword. Bit 0 is received first; bits [7:0] = data, [8] = p1, [9] = p2, [10] = p3.
- code_valid  out  1  code_word holds an undelivered codeword.
- code_ready  in  1  consumer accepts code_word when code_valid && code_ready.
- framing_error  out  1  one-cycle pulse: stop bit sampled low.
- overrun  out  1  one-cycle pulse: a codeword completed while the holding register was still full.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; all counters 0; shift register 0.
  - code_word=0, code_valid=0, framing_error=0, overrun=0, busy=0.
  - Synchronizer flops reset to 1 (idle).
  - Reset mid-frame abandons the frame; no output is produced for it.
- rx_s is the synchronized rx_line, delayed SYNC_STAGES cycles. All decisions use rx_s.
- Frame format: start(0), 11 bits LSB first, stop(1).
- Counters:
  - baud_cnt counts 0..CLKS_PER_BIT-1.
  - bit_idx counts 0..10.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: when rx_s==0 → START, baud_cnt=0.
  - START: when baud_cnt==HALF-1, sample rx_s.
    - 0 → DATA, baud_cnt=0, bit_idx=0.
    - 1 → IDLE (glitch, false start). No flags raised.
    - Otherwise baud_cnt++.
  - DATA: when baud_cnt==CLKS_PER_BIT-1, shift[bit_idx]=rx_s and baud_cnt=0.
    - If bit_idx==10 → STOP; otherwise bit_idx++.
    - Sampling therefore lands mid-bit.
  - STOP: when baud_cnt==CLKS_PER_BIT-1, sample rx_s, then → IDLE.
    - 1 → deliver the word (see below).
    - 0 → pulse framing_error next cycle and discard the word.
    - A stop bit held low keeps rx_s==0, so IDLE immediately re-enters START. This is intended; false-start filtering handles it.
- Delivery (cycle after a good stop sample):
  - If code_valid==0, or a handshake happens that same cycle: code_word←shift, code_valid=1.
  - Otherwise: code_word and code_valid are unchanged, the new word is dropped, and overrun pulses.
- Handshake:
  - code_valid falls the cycle after code_valid && code_ready, unless a new word loads that same cycle; then code_valid stays 1 with the new word.
  - code_word is stable while code_valid==1 and not accepted.
  - code_ready while code_valid==0 has no effect.
- Latency: code_valid rises 1 clk after the mid-stop sample, i.e. about (12 + 1/2)·CLKS_PER_BIT + SYNC_STAGES + 1 cycles after the start edge at the pin.
- Back-to-back frames: the FSM returns to IDLE mid-stop bit, so a start bit immediately after the stop bit is caught with no lost frame.
- No parity checking here; the word passes through as received.
- busy=1 in START/DATA/STOP.

Test Plan:
- CLKS_PER_BIT=4, code_ready=1. Send codeword 0x3A5 (data 0xA5, p1=1, p2=1, p3=0) → code_word=0x3A5, code_valid high exactly 1 cycle, framing_error=0, overrun=0.
- Low glitch of 1 clk (< HALF) on idle line → FSM returns to IDLE, busy drops, no code_valid, no flags.
- Frame 0x155 with stop bit driven 0 → framing_error pulses once, code_valid stays 0. Next good frame 0x2AA → delivered correctly.
- code_ready=0. Send 0x3A5 then 0x0F0 back-to-back → code_valid=1 holding 0x3A5, overrun pulses once at the second frame's end. Raise code_ready → 0x3A5 accepted, code_valid drops, 0x0F0 never appears.
- code_ready toggled so the handshake coincides with the completion of the second frame → code_valid stays 1 and code_word changes 0x3A5→0x0F0 with no overrun.
- Assert rst_n low mid-DATA (bit_idx=5), release, send 0x7FF → outputs at reset values during reset; afterwards exactly one word 0x7FF delivered.
